// File: rtl/mpx_hilo_ctrl.sv
// HI/LO register pair with MULT/DIV sequencing and interlock for the MPX core.
// Optional MFHI/MFLO completion-cycle forwarding is enabled by defining MPX_HILO_FWD_EN.
module mpx_hilo_ctrl #(
    parameter int MULT_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [31:0] opcode_rs_operand_i,
    input  logic [31:0] opcode_rt_operand_i,
    input  logic        hold_i,
    input  logic        mul_valid_i,
    input  logic [31:0] mul_hi_i,
    input  logic [31:0] mul_lo_i,
    input  logic        div_valid_i,
    input  logic [31:0] div_hi_i,
    input  logic [31:0] div_lo_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic        stall_o,
    output logic        busy_o,
    output logic [31:0] mf_result_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE,
        MUL_PEND,
        DIV_PEND
    } state_e;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q;

    logic [5:0]  funct;
    logic        is_special;
    logic        is_mf, is_mt, is_mul, is_div;
    logic        is_hilo_cls;
    logic        idle;
    logic        mul_done, div_done, completing;
    logic        fwd_ok;
    logic        accept;
    logic        issue_mul, issue_div, issue_mthi, issue_mtlo;

    // The rt operand feeds the multiplier/divider directly; it is not needed here.
    logic unused_ok;
    assign unused_ok = ^{opcode_rt_operand_i, opcode_opcode_i[25:6]} ^ (MULT_STAGES == 2);

    assign funct      = opcode_opcode_i[5:0];
    assign is_special = (opcode_opcode_i[31:26] == 6'b0);
    assign is_mf      = (funct == F_MFHI) || (funct == F_MFLO);
    assign is_mt      = (funct == F_MTHI) || (funct == F_MTLO);
    assign is_mul     = (funct == F_MULT) || (funct == F_MULTU);
    assign is_div     = (funct == F_DIV)  || (funct == F_DIVU);

    assign is_hilo_cls = opcode_valid_i & is_special & (is_mf | is_mt | is_mul | is_div);
    assign idle        = (state_q == IDLE);

    assign mul_done   = (state_q == MUL_PEND) & mul_valid_i & ~hold_i;
    assign div_done   = (state_q == DIV_PEND) & div_valid_i & ~hold_i;
    assign completing = mul_done | div_done;

`ifdef MPX_HILO_FWD_EN
    assign fwd_ok = is_mf & completing;
`else
    assign fwd_ok = 1'b0;
`endif

    assign stall_o = is_hilo_cls & ~idle & ~fwd_ok;
    assign accept  = opcode_valid_i & ~hold_i & ~stall_o;

    assign issue_mul  = accept & is_special & idle & is_mul;
    assign issue_div  = accept & is_special & idle & is_div;
    assign issue_mthi = accept & is_special & idle & (funct == F_MTHI);
    assign issue_mtlo = accept & is_special & idle & (funct == F_MTLO);

    assign div_start_o  = issue_div;
    assign div_signed_o = issue_div & ~funct[0];

    always_comb begin
        mf_result_o = '0;
        if (opcode_valid_i && is_special && is_mf) begin
            if (idle) begin
                mf_result_o = (funct == F_MFHI) ? hi_q : lo_q;
            end
`ifdef MPX_HILO_FWD_EN
            else if (completing) begin
                if (funct == F_MFHI) mf_result_o = mul_done ? mul_hi_i : div_hi_i;
                else                 mf_result_o = mul_done ? mul_lo_i : div_lo_i;
            end
`endif
        end
    end

    // NOTE: every signal gets its hold value before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (issue_mul) state_d = MUL_PEND;
                if (issue_div) state_d = DIV_PEND;
                if (issue_mthi) hi_d = opcode_rs_operand_i;
                if (issue_mtlo) lo_d = opcode_rs_operand_i;
            end
            MUL_PEND: begin
                if (mul_done) begin
                    state_d = IDLE;
                    hi_d    = mul_hi_i;
                    lo_d    = mul_lo_i;
                end
            end
            DIV_PEND: begin
                if (div_done) begin
                    state_d = IDLE;
                    hi_d    = div_hi_i;
                    lo_d    = div_lo_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous and wins over hold_i; all state uses non-blocking assignments.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign busy_o = busy_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mpx_hilo_ctrl.sv
// Self-checking bench for mpx_hilo_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the HI/LO unit.
module tb_mpx_hilo_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        opcode_valid_i;
    logic [31:0] opcode_opcode_i;
    logic [31:0] opcode_rs_operand_i;
    logic [31:0] opcode_rt_operand_i;
    logic        hold_i;
    logic        mul_valid_i;
    logic [31:0] mul_hi_i, mul_lo_i;
    logic        div_valid_i;
    logic [31:0] div_hi_i, div_lo_i;
    logic        div_start_o, div_signed_o, stall_o, busy_o;
    logic [31:0] mf_result_o, hi_o, lo_o;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MPX_HILO_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    mpx_hilo_ctrl #(.MULT_STAGES(2)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .opcode_valid_i      (opcode_valid_i),
        .opcode_opcode_i     (opcode_opcode_i),
        .opcode_rs_operand_i (opcode_rs_operand_i),
        .opcode_rt_operand_i (opcode_rt_operand_i),
        .hold_i              (hold_i),
        .mul_valid_i         (mul_valid_i),
        .mul_hi_i            (mul_hi_i),
        .mul_lo_i            (mul_lo_i),
        .div_valid_i         (div_valid_i),
        .div_hi_i            (div_hi_i),
        .div_lo_i            (div_lo_i),
        .div_start_o         (div_start_o),
        .div_signed_o        (div_signed_o),
        .stall_o             (stall_o),
        .busy_o              (busy_o),
        .mf_result_o         (mf_result_o),
        .hi_o                (hi_o),
        .lo_o                (lo_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: architectural HI/LO and which operation (if any) is outstanding.
    typedef enum int {P_NONE, P_MUL, P_DIV} pend_e;
    pend_e       m_pend = P_NONE;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] f);
        logic [19:0] mid;
        mid = 20'($urandom);
        return {6'b0, mid, f};
    endfunction

    task automatic clear_in();
        rst_i = 0; opcode_valid_i = 0; opcode_opcode_i = '0;
        opcode_rs_operand_i = '0; opcode_rt_operand_i = '0; hold_i = 0;
        mul_valid_i = 0; mul_hi_i = '0; mul_lo_i = '0;
        div_valid_i = 0; div_hi_i = '0; div_lo_i = '0;
    endtask

    task automatic instr(input logic [5:0] f, input logic [31:0] rs);
        opcode_valid_i = 1; opcode_opcode_i = mk(f);
        opcode_rs_operand_i = rs; opcode_rt_operand_i = $urandom;
    endtask

    // Expected outputs for the current inputs and model state, then the model's next state.
    task automatic compare_and_advance();
        logic [5:0]  f;
        logic        spec, cls, mf, done, stall_e, acc, dstart_e;
        logic [31:0] mf_e;
        f    = opcode_opcode_i[5:0];
        spec = (opcode_opcode_i[31:26] == 0);
        mf   = spec && (f == 6'h10 || f == 6'h12);
        cls  = opcode_valid_i && spec && (f inside {[6'h10:6'h13], [6'h18:6'h1B]});
        done = !hold_i && ((m_pend == P_MUL && mul_valid_i) || (m_pend == P_DIV && div_valid_i));
        stall_e  = cls && m_pend != P_NONE && !(FWD && mf && done);
        acc      = opcode_valid_i && !hold_i && !stall_e;
        dstart_e = acc && spec && m_pend == P_NONE && (f == 6'h1A || f == 6'h1B);
        mf_e = '0;
        if (opcode_valid_i && mf) begin
            if (m_pend == P_NONE) mf_e = (f == 6'h10) ? m_hi : m_lo;
            else if (FWD && done) begin
                if (m_pend == P_MUL) mf_e = (f == 6'h10) ? mul_hi_i : mul_lo_i;
                else                 mf_e = (f == 6'h10) ? div_hi_i : div_lo_i;
            end
        end
        check("stall", 32'(stall_o), 32'(stall_e));
        check("div_start", 32'(div_start_o), 32'(dstart_e));
        if (dstart_e) check("div_signed", 32'(div_signed_o), 32'(f == 6'h1A));
        check("busy", 32'(busy_o), 32'(m_pend != P_NONE));
        check("hi", hi_o, m_hi);
        check("lo", lo_o, m_lo);
        check("mf_result", mf_result_o, mf_e);

        if (rst_i) begin
            m_pend = P_NONE; m_hi = '0; m_lo = '0;
        end else if (done) begin
            if (m_pend == P_MUL) begin m_hi = mul_hi_i; m_lo = mul_lo_i; end
            else                 begin m_hi = div_hi_i; m_lo = div_lo_i; end
            m_pend = P_NONE;
        end else if (acc && spec && m_pend == P_NONE) begin
            case (f)
                6'h11: m_hi = opcode_rs_operand_i;
                6'h13: m_lo = opcode_rs_operand_i;
                6'h18, 6'h19: m_pend = P_MUL;
                6'h1A, 6'h1B: m_pend = P_DIV;
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        #1;
        compare_and_advance();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        clear_in();
        rst_i = 1;
        @(negedge clk_i);
        #1;
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        tick();
        clear_in();

        // MULT then MFLO right behind it.
        instr(6'h18, 32'hFFFF_FFFF); opcode_rt_operand_i = 32'h2;
        tick();
        instr(6'h12, 32'h0);
        #1;
        check("mul_busy_n1", 32'(busy_o), 32'h1);
        check("mflo_stall_n1", 32'(stall_o), 32'h1);
        tick();
        mul_valid_i = 1; mul_hi_i = 32'hFFFF_FFFF; mul_lo_i = 32'hFFFF_FFFE;
        #1;
        check("mul_busy_n2", 32'(busy_o), 32'h1);
`ifdef MPX_HILO_FWD_EN
        check("mflo_stall_n2", 32'(stall_o), 32'h0);
        check("mflo_fwd_n2", mf_result_o, 32'hFFFF_FFFE);
`else
        check("mflo_stall_n2", 32'(stall_o), 32'h1);
`endif
        tick();
        mul_valid_i = 0;
        #1;
        check("mul_hi_n3", hi_o, 32'hFFFF_FFFF);
        check("mul_lo_n3", lo_o, 32'hFFFF_FFFE);
        check("mflo_n3", mf_result_o, 32'hFFFF_FFFE);
        check("mul_busy_n3", 32'(busy_o), 32'h0);
        tick();
        clear_in();

        // DIVU launch, second DIV interlocked until completion.
        instr(6'h1B, 32'd7); opcode_rt_operand_i = 32'd2;
        #1;
        check("divu_start", 32'(div_start_o), 32'h1);
        check("divu_signed", 32'(div_signed_o), 32'h0);
        tick();
        instr(6'h1A, 32'd9);
        #1;
        check("div2_stall", 32'(stall_o), 32'h1);
        check("div2_nostart", 32'(div_start_o), 32'h0);
        tick();
        div_valid_i = 1; div_hi_i = 32'd1; div_lo_i = 32'd3;
        tick();
        div_valid_i = 0;
        #1;
        check("div2_start", 32'(div_start_o), 32'h1);
        check("div2_signed", 32'(div_signed_o), 32'h1);
        check("divu_hi", hi_o, 32'd1);
        check("divu_lo", lo_o, 32'd3);
        tick();
        opcode_valid_i = 0;
        div_valid_i = 1; div_hi_i = $urandom; div_lo_i = $urandom;
        tick();
        clear_in();

        // MTHI then MFHI, with a stray multiplier pulse.
        instr(6'h11, 32'h1234_5678);
        #1;
        check("mthi_stall", 32'(stall_o), 32'h0);
        tick();
        instr(6'h10, 32'h0);
        mul_valid_i = 1; mul_hi_i = 32'hDEAD_BEEF; mul_lo_i = 32'hDEAD_BEEF;
        #1;
        check("mfhi_val", mf_result_o, 32'h1234_5678);
        check("mfhi_stall", 32'(stall_o), 32'h0);
        tick();
        clear_in();
        #1;
        check("stray_hi", hi_o, 32'h1234_5678);
        tick();

        // Hold during the completion cycle.
        instr(6'h19, 32'h5);
        tick();
        opcode_valid_i = 0;
        tick();
        instr(6'h10, 32'h0); hold_i = 1;
        mul_valid_i = 1; mul_hi_i = 32'hA5A5_A5A5; mul_lo_i = 32'h5A5A_5A5A;
        #1;
        check("hold_stall", 32'(stall_o), 32'h1);
        tick();
        #1;
        check("hold_hi", hi_o, 32'h1234_5678);
        check("hold_busy", 32'(busy_o), 32'h1);
        hold_i = 0;
        tick();
        clear_in();
        #1;
        check("release_hi", hi_o, 32'hA5A5_A5A5);
        check("release_lo", lo_o, 32'h5A5A_5A5A);
        tick();

        // Reset while a divide is outstanding, then a stray completion.
        instr(6'h1A, 32'h40);
        tick();
        clear_in(); rst_i = 1;
        tick();
        rst_i = 0; div_valid_i = 1; div_hi_i = 32'h99; div_lo_i = 32'h77;
        #1;
        check("rst_mid_busy", 32'(busy_o), 32'h0);
        check("rst_mid_hi", hi_o, 32'h0);
        tick();
        clear_in();
        #1;
        check("stray_div_lo", lo_o, 32'h0);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            int          r;
            logic [5:0]  f;
            clear_in();
            rst_i  = ($urandom_range(0, 199) == 0);
            hold_i = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 99) < 70) begin
                r = $urandom_range(0, 9);
                case (r)
                    0: f = 6'h10; 1: f = 6'h11; 2: f = 6'h12; 3: f = 6'h13;
                    4: f = 6'h18; 5: f = 6'h19; 6: f = 6'h1A; 7: f = 6'h1B;
                    8: f = 6'h20;
                    default: f = 6'($urandom_range(0, 63));
                endcase
                instr(f, $urandom);
                if ($urandom_range(0, 9) == 0) opcode_opcode_i[31:26] = 6'($urandom_range(1, 63));
            end
            mul_hi_i = $urandom; mul_lo_i = $urandom;
            div_hi_i = $urandom; div_lo_i = $urandom;
            mul_valid_i = (m_pend == P_MUL) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
            div_valid_i = (m_pend == P_DIV) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 5);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
